// File: rtl/y1_word_loader_if.sv
// Nibble-in / word-out handshake bundle for y1_word_loader.
// in_par exists only when Y1_PARITY_EN is defined.
interface y1_word_loader_if;
  logic [3:0]  in_nib;
  logic        in_valid;
  logic        in_ready;
`ifdef Y1_PARITY_EN
  logic        in_par;
`endif
  logic        flush;
  logic [15:0] pi;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  err_cnt;

`ifdef Y1_PARITY_EN
  modport master (output in_nib, in_valid, in_par, flush, word_ready,
                  input  in_ready, pi, word_valid, err_cnt);
  modport slave  (input  in_nib, in_valid, in_par, flush, word_ready,
                  output in_ready, pi, word_valid, err_cnt);
`else
  modport master (output in_nib, in_valid, flush, word_ready,
                  input  in_ready, pi, word_valid, err_cnt);
  modport slave  (input  in_nib, in_valid, flush, word_ready,
                  output in_ready, pi, word_valid, err_cnt);
`endif
endinterface

// File: rtl/y1_word_loader.sv
// Packs four 4-bit nibbles (first nibble in pi[3:0]) into a 16-bit word with valid/ready on both sides.
// Optional odd-parity checking with bad-word drop and saturating error count: macro Y1_PARITY_EN.
module y1_word_loader (
  input  logic              clk,
  input  logic              rst,
  y1_word_loader_if.slave   bus
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ERR_W  = 8;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]        state_q,   state_d;
  logic [CNT_W-1:0]  nib_cnt_q, nib_cnt_d;
  logic [WORD_W-1:0] pi_q,      pi_d;
  logic              bad_q,     bad_d;
  logic [ERR_W-1:0]  err_q,     err_d;

  logic in_ready_c;
  logic acc_c;
  logic xfer_c;
  logic nib_bad_c;

`ifdef Y1_PARITY_EN
  assign nib_bad_c = ~(^{bus.in_nib, bus.in_par});
`else
  assign nib_bad_c = 1'b0;
`endif

  // Ready is forced low during reset; in FULL a new nibble is taken only as the held word leaves.
  assign in_ready_c = rst ? 1'b0 : ((state_q == FILL) ? 1'b1 : bus.word_ready);
  assign acc_c      = bus.in_valid & in_ready_c;
  assign xfer_c     = (state_q == FULL) & bus.word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      nib_cnt_q <= '0;
      pi_q      <= '0;
      bad_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      pi_q      <= pi_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    pi_d      = pi_q;
    bad_d     = bad_q;
    err_d     = err_q;
    unique case (state_q)
      FILL: begin
        if (bus.flush) begin
          nib_cnt_d = '0;
          bad_d     = 1'b0;
        end else if (acc_c) begin
          pi_d[{nib_cnt_q, 2'b00} +: NIB_W] = bus.in_nib;
          if (nib_cnt_q == CNT_W'(3)) begin
            nib_cnt_d = '0;
            bad_d     = 1'b0;
            // A word with any parity failure is dropped here instead of being presented.
            if (bad_q | nib_bad_c) begin
              if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            end else begin
              state_d = FULL;
            end
          end else begin
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
            bad_d     = bad_q | nib_bad_c;
          end
        end
      end
      FULL: begin
        if (xfer_c) begin
          state_d   = FILL;
          nib_cnt_d = '0;
          bad_d     = 1'b0;
          // Back-to-back: the nibble arriving with the transfer starts the next word.
          if (acc_c && !bus.flush) begin
            pi_d[NIB_W-1:0] = bus.in_nib;
            nib_cnt_d       = CNT_W'(1);
            bad_d           = nib_bad_c;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.word_valid = (state_q == FULL);
  assign bus.pi         = pi_q;
  assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_y1_word_loader.sv
// Directed-vector bench for y1_word_loader: per-cycle table plus streaming and parity sequences.
module tb_y1_word_loader;

  logic clk;
  logic rst;
  y1_word_loader_if bus ();

  y1_word_loader dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  nib;
    logic        vld;
    logic        fl;
    logic        wr;
    logic        e_rdy;
    logic        e_wv;
    logic [15:0] e_pi;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t v(input logic r, input logic [3:0] nib, input logic vld, input logic fl,
                             input logic wr, input logic e_rdy, input logic e_wv, input logic [15:0] e_pi);
    vec_t t;
    t = '{rst: r, nib: nib, vld: vld, fl: fl, wr: wr, e_rdy: e_rdy, e_wv: e_wv, e_pi: e_pi};
    return t;
  endfunction

  task automatic drive(input logic r, input logic [3:0] nib, input logic vld, input logic fl,
                       input logic wr, input logic par_ok);
    rst            = r;
    bus.in_nib     = nib;
    bus.in_valid   = vld;
    bus.flush      = fl;
    bus.word_ready = wr;
`ifdef Y1_PARITY_EN
    bus.in_par     = par_ok ? ~(^nib) : (^nib);
`else
    if (par_ok) begin end
`endif
  endtask

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int wv_seen;
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // rst nib vld fl wr | rdy wv pi  (outputs observed before the edge that consumes the inputs)
    vecs.push_back(v(1, 4'h0, 0, 0, 0, 0, 0, 16'h0000));
    // C,2,6,4 held, then handed off with A arriving
    vecs.push_back(v(0, 4'hC, 1, 0, 0, 1, 0, 16'h0000));
    vecs.push_back(v(0, 4'h2, 1, 0, 0, 1, 0, 16'h000C));
    vecs.push_back(v(0, 4'h6, 1, 0, 0, 1, 0, 16'h002C));
    vecs.push_back(v(0, 4'h4, 1, 0, 0, 1, 0, 16'h062C));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 0, 1, 16'h462C));
    vecs.push_back(v(0, 4'h5, 1, 0, 0, 0, 1, 16'h462C));
    vecs.push_back(v(0, 4'hA, 1, 0, 1, 1, 1, 16'h462C));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'h462A));
    vecs.push_back(v(0, 4'hB, 1, 0, 0, 1, 0, 16'h462A));
    vecs.push_back(v(0, 4'hC, 1, 0, 0, 1, 0, 16'h46BA));
    vecs.push_back(v(0, 4'hD, 1, 0, 0, 1, 0, 16'h4CBA));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 1, 16'hDCBA));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 0, 16'hDCBA));
    // 1..8 streamed with word_ready high
    vecs.push_back(v(0, 4'h1, 1, 0, 1, 1, 0, 16'hDCBA));
    vecs.push_back(v(0, 4'h2, 1, 0, 1, 1, 0, 16'hDCB1));
    vecs.push_back(v(0, 4'h3, 1, 0, 1, 1, 0, 16'hDC21));
    vecs.push_back(v(0, 4'h4, 1, 0, 1, 1, 0, 16'hD321));
    vecs.push_back(v(0, 4'h5, 1, 0, 1, 1, 1, 16'h4321));
    vecs.push_back(v(0, 4'h6, 1, 0, 1, 1, 0, 16'h4325));
    vecs.push_back(v(0, 4'h7, 1, 0, 1, 1, 0, 16'h4365));
    vecs.push_back(v(0, 4'h8, 1, 0, 1, 1, 0, 16'h4765));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 1, 16'h8765));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'h8765));
    // flush in FILL together with nibble 3
    vecs.push_back(v(0, 4'h1, 1, 0, 0, 1, 0, 16'h8765));
    vecs.push_back(v(0, 4'h2, 1, 0, 0, 1, 0, 16'h8761));
    vecs.push_back(v(0, 4'h3, 1, 1, 0, 1, 0, 16'h8721));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'h8721));
    vecs.push_back(v(0, 4'h5, 1, 0, 0, 1, 0, 16'h8721));
    vecs.push_back(v(0, 4'h6, 1, 0, 0, 1, 0, 16'h8725));
    vecs.push_back(v(0, 4'h7, 1, 0, 0, 1, 0, 16'h8765));
    vecs.push_back(v(0, 4'h8, 1, 0, 0, 1, 0, 16'h8765));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 0, 1, 16'h8765));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 1, 16'h8765));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'h8765));
    // reset mid-word, then F,F,F,F
    vecs.push_back(v(0, 4'h1, 1, 0, 0, 1, 0, 16'h8765));
    vecs.push_back(v(0, 4'h2, 1, 0, 0, 1, 0, 16'h8761));
    vecs.push_back(v(0, 4'h3, 1, 0, 0, 1, 0, 16'h8721));
    vecs.push_back(v(1, 4'h0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(v(0, 4'hF, 1, 0, 0, 1, 0, 16'h0000));
    vecs.push_back(v(0, 4'hF, 1, 0, 0, 1, 0, 16'h000F));
    vecs.push_back(v(0, 4'hF, 1, 0, 0, 1, 0, 16'h00FF));
    vecs.push_back(v(0, 4'hF, 1, 0, 0, 1, 0, 16'h0FFF));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 1, 16'hFFFF));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'hFFFF));
    // reset while a word is held
    vecs.push_back(v(0, 4'h1, 1, 0, 0, 1, 0, 16'hFFFF));
    vecs.push_back(v(0, 4'h2, 1, 0, 0, 1, 0, 16'hFFF1));
    vecs.push_back(v(0, 4'h3, 1, 0, 0, 1, 0, 16'hFF21));
    vecs.push_back(v(0, 4'h4, 1, 0, 0, 1, 0, 16'hF321));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 0, 1, 16'h4321));
    vecs.push_back(v(1, 4'h0, 0, 0, 1, 0, 0, 16'h0000));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 0, 16'h0000));
    // flush in FULL leaves the held word, drops only the incoming nibble
    vecs.push_back(v(0, 4'h1, 1, 0, 0, 1, 0, 16'h0000));
    vecs.push_back(v(0, 4'h2, 1, 0, 0, 1, 0, 16'h0001));
    vecs.push_back(v(0, 4'h3, 1, 0, 0, 1, 0, 16'h0021));
    vecs.push_back(v(0, 4'h4, 1, 0, 0, 1, 0, 16'h0321));
    vecs.push_back(v(0, 4'h9, 1, 1, 0, 0, 1, 16'h4321));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 0, 1, 16'h4321));
    vecs.push_back(v(0, 4'h9, 1, 1, 1, 1, 1, 16'h4321));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'h4321));
    vecs.push_back(v(0, 4'hA, 1, 0, 0, 1, 0, 16'h4321));
    vecs.push_back(v(0, 4'hB, 1, 0, 0, 1, 0, 16'h432A));
    vecs.push_back(v(0, 4'hC, 1, 0, 0, 1, 0, 16'h43BA));
    vecs.push_back(v(0, 4'hD, 1, 0, 0, 1, 0, 16'h4CBA));
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 1, 1, 16'hDCBA));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, 0, 16'hDCBA));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].nib, vecs[i].vld, vecs[i].fl, vecs[i].wr, 1'b1);
      #1;
      chk1 ("in_ready",   i, bus.in_ready,   vecs[i].e_rdy);
      chk1 ("word_valid", i, bus.word_valid, vecs[i].e_wv);
      chk16("pi",         i, bus.pi,         vecs[i].e_pi);
      chk16("err_cnt",    i, 16'(bus.err_cnt), 16'h0000);
    end

    // Sustained streaming: 12 nibbles back-to-back give a word every 4 cycles, no in_ready stall
    wv_seen = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(1'b0, 4'(i), (i < 12), 1'b0, 1'b1, 1'b1);
      #1;
      chk1("stream_rdy", i, bus.in_ready, 1'b1);
      chk1("stream_wv",  i, bus.word_valid, (i == 4) || (i == 8) || (i == 12));
      if (bus.word_valid) wv_seen++;
      if (i == 4)  chk16("stream_pi", i, bus.pi, 16'h3210);
      if (i == 8)  chk16("stream_pi", i, bus.pi, 16'h7654);
      if (i == 12) chk16("stream_pi", i, bus.pi, 16'hBA98);
    end
    chk16("stream_words", 0, 16'(wv_seen), 16'd3);

`ifdef Y1_PARITY_EN
    // Bad 2nd nibble drops the word and counts it; the count saturates at 255
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive(1'b0, 4'(k + 1), 1'b1, 1'b0, 1'b0, (k != 1));
        #1;
        chk1("par_wv", w, bus.word_valid, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk1("par_drop_wv", w, bus.word_valid, 1'b0);
      if (w == 0) chk16("par_err1", w, 16'(bus.err_cnt), 16'd1);
    end
    chk16("par_err_sat", 0, 16'(bus.err_cnt), 16'd255);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 4'(k + 5), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk1 ("par_good_wv", 0, bus.word_valid, 1'b1);
    chk16("par_good_pi", 0, bus.pi, 16'h8765);
    chk16("par_err_hold", 0, 16'(bus.err_cnt), 16'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
